// File: rtl/jogo_pkg.sv
// Shared definitions for the game sequencer and the entity blocks (nave, fileira).
// Holds the state encoding and the default sizing constants.
package jogo_pkg;

    typedef enum logic [2:0] {
        INICIO       = 3'd0,
        JOGANDO      = 3'd1,
        PAUSADO      = 3'd2,
        VIDA_PERDIDA = 3'd3,
        ONDA_LIMPA   = 3'd4,
        FIM          = 3'd5
    } estado_t;

    localparam int DIV_MV_PADRAO     = 320000;
    localparam int N_INIMIGOS_PADRAO = 5;

endpackage

// File: rtl/jogo_sequenciador_detector_borda.sv
// Two-flop synchronizer followed by a rising-edge detector for one raw button.
// The edge pulse is one cycle wide, however long the button stays pressed.
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic borda
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer chain plus the delayed copy used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign borda = sync2_r & ~prev_r;

endmodule

// File: rtl/jogo_sequenciador.sv
// Game sequencer: owns the game FSM, pause/restart control, the enemy movement tick,
// wave number and score.
module jogo_sequenciador
    import jogo_pkg::*;
#(
    parameter int DIV_MV         = DIV_MV_PADRAO,
    parameter int FREEZE_TICKS   = 64,
    parameter int PONTOS_INIMIGO = 10,
    parameter int N_INIMIGOS     = N_INIMIGOS_PADRAO
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  btn_start,
    input  logic                  btn_pausa,
    input  logic                  perdeu,
    input  logic [1:0]            vidas,
    input  logic [N_INIMIGOS-1:0] inimigo_vivo,
    output logic                  pausa,
    output logic                  reiniciarJogo,
    output logic                  mv_tick,
    output logic [2:0]            estado,
    output logic [3:0]            onda,
    output logic [15:0]           pontuacao
);

    localparam int CW = (DIV_MV > 1) ? $clog2(DIV_MV) : 1;
    localparam int FW = $clog2(FREEZE_TICKS + 1);
    localparam int KW = $clog2(N_INIMIGOS + 1);

    estado_t               estado_r;
    logic                  pausa_r;
    logic                  reiniciar_r;
    logic                  mv_tick_r;
    logic [3:0]            onda_r;
    logic [15:0]           pont_r;
    logic [CW-1:0]         div_r;
    logic [FW-1:0]         frz_r;
    logic [1:0]            vidas_prev_r;
    logic [N_INIMIGOS-1:0] vivo_prev_r;

    logic                  start_borda_s;
    logic                  pausa_borda_s;
    logic                  tick_raw_s;
    logic                  frz_fim_s;
    logic [KW-1:0]         kills_s;
    logic [31:0]           ganho_s;
    logic [32:0]           soma_s;
    logic [15:0]           pont_soma_s;

    function automatic logic [KW-1:0] popcount(input logic [N_INIMIGOS-1:0] v);
        logic [KW-1:0] c;
        c = '0;
        for (int i = 0; i < N_INIMIGOS; i++) begin
            c = c + KW'(v[i]);
        end
        return c;
    endfunction

    detector_borda u_borda_start (
        .clk   (CLOCK_50),
        .rst_n (reset),
        .btn   (btn_start),
        .borda (start_borda_s)
    );

    detector_borda u_borda_pausa (
        .clk   (CLOCK_50),
        .rst_n (reset),
        .btn   (btn_pausa),
        .borda (pausa_borda_s)
    );

    assign tick_raw_s = (div_r == CW'(DIV_MV - 1));
    assign frz_fim_s  = tick_raw_s && (frz_r == FW'(FREEZE_TICKS - 1));

    // Kill score for this cycle: enemies that were alive last cycle and are dead now
    always_comb begin
        kills_s = popcount(vivo_prev_r & ~inimigo_vivo);
        ganho_s = 32'(kills_s) * 32'(PONTOS_INIMIGO);
        soma_s  = {17'd0, pont_r} + {1'b0, ganho_s};
        if (soma_s > 33'h0_0000_FFFF) begin
            pont_soma_s = 16'hFFFF;
        end else begin
            pont_soma_s = soma_s[15:0];
        end
    end

    // Free-running movement divider; wraps once every DIV_MV cycles
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            div_r <= '0;
        end else if (tick_raw_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + CW'(1);
        end
    end

    // Game FSM with registered outputs, history registers and freeze counter
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            estado_r     <= INICIO;
            pausa_r      <= 1'b1;
            reiniciar_r  <= 1'b0;
            mv_tick_r    <= 1'b0;
            onda_r       <= 4'd0;
            pont_r       <= 16'd0;
            frz_r        <= '0;
            vidas_prev_r <= 2'd0;
            vivo_prev_r  <= '0;
        end else begin
            vivo_prev_r  <= inimigo_vivo;
            vidas_prev_r <= vidas;
            pausa_r      <= (estado_r != JOGANDO);
            mv_tick_r    <= tick_raw_s && (estado_r == JOGANDO);
            reiniciar_r  <= 1'b0;
            case (estado_r)
                INICIO, FIM: begin
                    if (start_borda_s) begin
                        reiniciar_r <= 1'b1;
                        onda_r      <= 4'd1;
                        pont_r      <= 16'd0;
                        estado_r    <= JOGANDO;
                    end
                end
                JOGANDO: begin
                    // Kills are banked even when the cycle also leaves JOGANDO
                    pont_r <= pont_soma_s;
                    if (perdeu) begin
                        estado_r <= FIM;
                    end else if (vidas < vidas_prev_r) begin
                        frz_r    <= '0;
                        estado_r <= VIDA_PERDIDA;
                    end else if (inimigo_vivo == '0) begin
                        frz_r    <= '0;
                        estado_r <= ONDA_LIMPA;
                    end else if (pausa_borda_s) begin
                        estado_r <= PAUSADO;
                    end
                end
                PAUSADO: begin
                    if (pausa_borda_s) begin
                        estado_r <= JOGANDO;
                    end
                end
                VIDA_PERDIDA: begin
                    if (perdeu) begin
                        estado_r <= FIM;
                    end else if (frz_fim_s) begin
                        estado_r <= JOGANDO;
                    end else if (tick_raw_s) begin
                        frz_r <= frz_r + FW'(1);
                    end
                end
                ONDA_LIMPA: begin
                    if (frz_fim_s) begin
                        reiniciar_r <= 1'b1;
                        onda_r      <= (onda_r == 4'd15) ? 4'd15 : onda_r + 4'd1;
                        estado_r    <= JOGANDO;
                    end else if (tick_raw_s) begin
                        frz_r <= frz_r + FW'(1);
                    end
                end
                default: begin
                    estado_r <= INICIO;
                end
            endcase
        end
    end

    assign estado        = estado_r;
    assign pausa         = pausa_r;
    assign reiniciarJogo = reiniciar_r;
    assign mv_tick       = mv_tick_r;
    assign onda          = onda_r;
    assign pontuacao     = pont_r;

endmodule

// File: tb/tb_jogo_sequenciador.sv
// Self-checking bench for jogo_sequenciador with a small movement divider and short freezes.
module tb_jogo_sequenciador;

    logic        CLOCK_50;
    logic        reset;
    logic        btn_start;
    logic        btn_pausa;
    logic        perdeu;
    logic [1:0]  vidas;
    logic [4:0]  inimigo_vivo;
    logic        pausa;
    logic        reiniciarJogo;
    logic        mv_tick;
    logic [2:0]  estado;
    logic [3:0]  onda;
    logic [15:0] pontuacao;

    typedef struct {
        logic [2:0]  e;
        logic [3:0]  o;
        logic [15:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    jogo_sequenciador #(
        .DIV_MV         (4),
        .FREEZE_TICKS   (3),
        .PONTOS_INIMIGO (10),
        .N_INIMIGOS     (5)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .btn_start     (btn_start),
        .btn_pausa     (btn_pausa),
        .perdeu        (perdeu),
        .vidas         (vidas),
        .inimigo_vivo  (inimigo_vivo),
        .pausa         (pausa),
        .reiniciarJogo (reiniciarJogo),
        .mv_tick       (mv_tick),
        .estado        (estado),
        .onda          (onda),
        .pontuacao     (pontuacao)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) step();
        total += 6;
        if (estado !== 3'd0) begin bad++; $display("FAIL reset_estado: got %0d want 0", estado); end
        if (pausa !== 1'b1) begin bad++; $display("FAIL reset_pausa: got %0b want 1", pausa); end
        if (reiniciarJogo !== 1'b0) begin bad++; $display("FAIL reset_reiniciar: got %0b want 0", reiniciarJogo); end
        if (mv_tick !== 1'b0) begin bad++; $display("FAIL reset_mv_tick: got %0b want 0", mv_tick); end
        if (onda !== 4'd0) begin bad++; $display("FAIL reset_onda: got %0d want 0", onda); end
        if (pontuacao !== 16'd0) begin bad++; $display("FAIL reset_pontuacao: got %0d want 0", pontuacao); end
        reset = 1'b1;
        repeat (2) step();
        total++;
        if (estado !== 3'd0) begin bad++; $display("FAIL idle_estado: got %0d want 0", estado); end
    endtask

    task automatic test_start();
        exp_t x;
        int pulses = 0;
        exp_q.push_back('{3'd1, 4'd1, 16'd0});
        btn_start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (reiniciarJogo === 1'b1) pulses++;
            if (i == 3) begin
                x = exp_q.pop_front();
                total += 5;
                if (reiniciarJogo !== 1'b1) begin bad++; $display("FAIL start_pulse: got %0b want 1", reiniciarJogo); end
                if (estado !== x.e) begin bad++; $display("FAIL start_estado: got %0d want %0d", estado, x.e); end
                if (onda !== x.o) begin bad++; $display("FAIL start_onda: got %0d want %0d", onda, x.o); end
                if (pontuacao !== x.p) begin bad++; $display("FAIL start_pontuacao: got %0d want %0d", pontuacao, x.p); end
                if (pausa !== 1'b1) begin bad++; $display("FAIL start_pausa_lag: got %0b want 1", pausa); end
            end
            if (i == 4) begin
                total++;
                if (pausa !== 1'b0) begin bad++; $display("FAIL start_pausa: got %0b want 0", pausa); end
            end
            if (i == 10) btn_start = 1'b0;
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL start_one_pulse: got %0d want 1", pulses); end
    endtask

    task automatic test_mv_tick();
        int n = 0;
        int last = -1;
        int gap_bad = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (mv_tick === 1'b1) begin
                if (last >= 0 && (i - last) != 4) gap_bad++;
                last = i;
                n++;
            end
        end
        total += 2;
        if (n !== 4) begin bad++; $display("FAIL mv_tick_count: got %0d want 4", n); end
        if (gap_bad !== 0) begin bad++; $display("FAIL mv_tick_period: got %0d bad gaps want 0", gap_bad); end
    endtask

    task automatic test_score_onda();
        exp_t x;
        int n = 0;
        int tick_bad = 0;
        exp_q.push_back('{3'd1, 4'd1, 16'd20});
        inimigo_vivo = 5'b10110;
        step();
        x = exp_q.pop_front();
        total += 2;
        if (estado !== x.e) begin bad++; $display("FAIL kill2_estado: got %0d want %0d", estado, x.e); end
        if (pontuacao !== x.p) begin bad++; $display("FAIL kill2_pontuacao: got %0d want %0d", pontuacao, x.p); end
        exp_q.push_back('{3'd1, 4'd1, 16'd20});
        step();
        x = exp_q.pop_front();
        total++;
        if (pontuacao !== x.p) begin bad++; $display("FAIL kill_stable: got %0d want %0d", pontuacao, x.p); end
        exp_q.push_back('{3'd4, 4'd1, 16'd50});
        inimigo_vivo = 5'b00000;
        step();
        x = exp_q.pop_front();
        total += 2;
        if (estado !== x.e) begin bad++; $display("FAIL clear_estado: got %0d want %0d", estado, x.e); end
        if (pontuacao !== x.p) begin bad++; $display("FAIL clear_pontuacao: got %0d want %0d", pontuacao, x.p); end
        inimigo_vivo = 5'b11111;
        while (estado === 3'd4 && n < 20) begin
            step();
            n++;
            if (estado === 3'd4 && mv_tick === 1'b1) tick_bad++;
        end
        exp_q.push_back('{3'd1, 4'd2, 16'd50});
        x = exp_q.pop_front();
        total += 5;
        if (n < 9 || n > 12) begin bad++; $display("FAIL onda_freeze_len: got %0d cycles want 9..12", n); end
        if (tick_bad !== 0) begin bad++; $display("FAIL onda_mv_tick: got %0d pulses want 0", tick_bad); end
        if (reiniciarJogo !== 1'b1) begin bad++; $display("FAIL onda_pulse: got %0b want 1", reiniciarJogo); end
        if (estado !== x.e) begin bad++; $display("FAIL onda_estado: got %0d want %0d", estado, x.e); end
        if (onda !== x.o) begin bad++; $display("FAIL onda_num: got %0d want %0d", onda, x.o); end
        repeat (2) step();
        total++;
        if (pontuacao !== 16'd50) begin bad++; $display("FAIL respawn_score: got %0d want 50", pontuacao); end
    endtask

    task automatic test_vida();
        exp_t x;
        int n = 0;
        int pbad = 0;
        int rpulse = 0;
        exp_q.push_back('{3'd3, 4'd2, 16'd50});
        vidas = 2'd2;
        step();
        x = exp_q.pop_front();
        total++;
        if (estado !== x.e) begin bad++; $display("FAIL vida_estado: got %0d want %0d", estado, x.e); end
        while (estado === 3'd3 && n < 20) begin
            step();
            n++;
            if (estado === 3'd3 && pausa !== 1'b1) pbad++;
            if (reiniciarJogo === 1'b1) rpulse++;
        end
        exp_q.push_back('{3'd1, 4'd2, 16'd50});
        x = exp_q.pop_front();
        total += 4;
        if (n < 9 || n > 12) begin bad++; $display("FAIL vida_freeze_len: got %0d cycles want 9..12", n); end
        if (pbad !== 0) begin bad++; $display("FAIL vida_pausa: got %0d cycles unpaused want 0", pbad); end
        if (rpulse !== 0) begin bad++; $display("FAIL vida_no_pulse: got %0d want 0", rpulse); end
        if (estado !== x.e) begin bad++; $display("FAIL vida_return: got %0d want %0d", estado, x.e); end
    endtask

    task automatic test_pausa();
        exp_t x;
        int n = 0;
        btn_pausa = 1'b1;
        repeat (3) step();
        exp_q.push_back('{3'd2, 4'd2, 16'd50});
        x = exp_q.pop_front();
        total++;
        if (estado !== x.e) begin bad++; $display("FAIL pausa_enter: got %0d want %0d", estado, x.e); end
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) btn_pausa = 1'b0;
            if (mv_tick === 1'b1) n++;
        end
        total++;
        if (n !== 0) begin bad++; $display("FAIL pausa_mv_tick: got %0d pulses want 0", n); end
        btn_start = 1'b1;
        repeat (3) step();
        btn_start = 1'b0;
        repeat (3) step();
        exp_q.push_back('{3'd2, 4'd2, 16'd50});
        x = exp_q.pop_front();
        total++;
        if (estado !== x.e) begin bad++; $display("FAIL pausa_start_ignored: got %0d want %0d", estado, x.e); end
        btn_pausa = 1'b1;
        repeat (3) step();
        exp_q.push_back('{3'd1, 4'd2, 16'd50});
        x = exp_q.pop_front();
        total++;
        if (estado !== x.e) begin bad++; $display("FAIL pausa_exit: got %0d want %0d", estado, x.e); end
        btn_pausa = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_fim();
        exp_t x;
        exp_q.push_back('{3'd5, 4'd2, 16'd100});
        perdeu = 1'b1;
        vidas = 2'd1;
        inimigo_vivo = 5'b00000;
        step();
        x = exp_q.pop_front();
        total += 2;
        if (estado !== x.e) begin bad++; $display("FAIL fim_estado: got %0d want %0d", estado, x.e); end
        if (pontuacao !== x.p) begin bad++; $display("FAIL fim_score: got %0d want %0d", pontuacao, x.p); end
        perdeu = 1'b0;
        vidas = 2'd3;
        inimigo_vivo = 5'b11111;
        repeat (3) step();
        exp_q.push_back('{3'd5, 4'd2, 16'd100});
        x = exp_q.pop_front();
        total++;
        if (pontuacao !== x.p) begin bad++; $display("FAIL fim_hold: got %0d want %0d", pontuacao, x.p); end
        exp_q.push_back('{3'd1, 4'd1, 16'd0});
        btn_start = 1'b1;
        repeat (3) step();
        x = exp_q.pop_front();
        total += 4;
        if (reiniciarJogo !== 1'b1) begin bad++; $display("FAIL restart_pulse: got %0b want 1", reiniciarJogo); end
        if (estado !== x.e) begin bad++; $display("FAIL restart_estado: got %0d want %0d", estado, x.e); end
        if (onda !== x.o) begin bad++; $display("FAIL restart_onda: got %0d want %0d", onda, x.o); end
        if (pontuacao !== x.p) begin bad++; $display("FAIL restart_score: got %0d want %0d", pontuacao, x.p); end
        btn_start = 1'b0;
        repeat (2) step();
        total++;
        if (estado !== 3'd1) begin bad++; $display("FAIL restart_stays: got %0d want 1", estado); end
    endtask

    task automatic test_reset_freeze();
        exp_t x;
        exp_q.push_back('{3'd4, 4'd1, 16'd50});
        inimigo_vivo = 5'b00000;
        step();
        x = exp_q.pop_front();
        total++;
        if (estado !== x.e) begin bad++; $display("FAIL rf_enter: got %0d want %0d", estado, x.e); end
        repeat (4) step();
        #2;
        reset = 1'b0;
        #1;
        total += 6;
        if (estado !== 3'd0) begin bad++; $display("FAIL rf_estado: got %0d want 0", estado); end
        if (pausa !== 1'b1) begin bad++; $display("FAIL rf_pausa: got %0b want 1", pausa); end
        if (reiniciarJogo !== 1'b0) begin bad++; $display("FAIL rf_reiniciar: got %0b want 0", reiniciarJogo); end
        if (mv_tick !== 1'b0) begin bad++; $display("FAIL rf_mv_tick: got %0b want 0", mv_tick); end
        if (onda !== 4'd0) begin bad++; $display("FAIL rf_onda: got %0d want 0", onda); end
        if (pontuacao !== 16'd0) begin bad++; $display("FAIL rf_pontuacao: got %0d want 0", pontuacao); end
    endtask

    initial begin
        reset        = 1'b0;
        btn_start    = 1'b0;
        btn_pausa    = 1'b0;
        perdeu       = 1'b0;
        vidas        = 2'd3;
        inimigo_vivo = 5'b11111;
        test_reset();
        test_start();
        test_mv_tick();
        test_score_onda();
        test_vida();
        test_pausa();
        test_fim();
        test_reset_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jogo_sequenciador.md
Name: jogo_sequenciador

Overview:
- Top-level game sequencer for the entities datapath (ship, enemy row, ally/enemy balls).
- Owns the game state machine and generates pausa, the one-cycle reiniciarJogo pulse and the enemy-movement tick (mv_tick). This replaces the ad-hoc CLOCK_MV divider.
- Also tracks wave number and score from enemy-kill events.

Parameters:
- DIV_MV, 320000, CLOCK_50 cycles between mv_tick pulses.
- FREEZE_TICKS, 64, mv tick periods spent frozen in VIDA_PERDIDA and ONDA_LIMPA.
- PONTOS_INIMIGO, 10, score added per enemy killed.
- N_INIMIGOS, 5, width of the enemy alive vector.

Ports:
- CLOCK_50 in 1: system clock.
- reset in 1: asynchronous, active-low reset.
- btn_start in 1: raw start button, active-high, asynchronous to the clock.
- btn_pausa in 1: raw pause button, active-high, asynchronous to the clock.
- perdeu in 1: game-lost flag from the nave block.
- vidas in 2: remaining lives from the nave block.
- inimigo_vivo in N_INIMIGOS: enemy alive bits.
- pausa out 1: freezes nave and fileira when 1.
- reiniciarJogo out 1: one-cycle respawn/restart pulse to nave and fileira.
- mv_tick out 1: one-cycle movement enable for enemies.
- estado out 3: current state encoding.
- onda out 4: current wave number.
- pontuacao out 16: score.

Behaviour:
- **Reset (reset=0, async):**
  - estado=INICIO, pausa=1, reiniciarJogo=0, mv_tick=0, onda=0, pontuacao=0.
  - Divider, freeze counter, synchronizers, vidas_prev and vivo_prev all cleared.
- **Buttons:** each passes a 2-FF synchronizer, then a rising-edge detect. Button edge to state change = 3 cycles. A level held high produces exactly one edge.
- **Divider:** free-running 0..DIV_MV-1. A raw tick fires when it wraps.
  - mv_tick = raw tick AND estado==JOGANDO. It is registered, so it is exactly 1 cycle wide.
  - The freeze counter advances on the raw tick.
- **States** (encoding: INICIO=0, JOGANDO=1, PAUSADO=2, VIDA_PERDIDA=3, ONDA_LIMPA=4, FIM=5). Outputs are registered, so pausa follows estado with 1-cycle latency.
  - INICIO: pausa=1. On start edge: reiniciarJogo=1 for 1 cycle, onda=1, pontuacao=0, go to JOGANDO.
  - JOGANDO: pausa=0. Transitions checked in this priority order:
    1. perdeu=1 -> FIM.
    2. vidas<vidas_prev -> VIDA_PERDIDA.
    3. inimigo_vivo==0 -> ONDA_LIMPA.
    4. pause edge -> PAUSADO.
  - PAUSADO: pausa=1. Pause edge -> JOGANDO. Start edges are ignored.
  - VIDA_PERDIDA: pausa=1. Freeze counter is cleared on entry. After FREEZE_TICKS raw ticks -> JOGANDO, with no reiniciarJogo. perdeu=1 here -> FIM immediately.
  - ONDA_LIMPA: pausa=1. After FREEZE_TICKS raw ticks: reiniciarJogo pulse, onda+1 (saturates at 15), go to JOGANDO.
  - FIM: pausa=1, pontuacao held. Start edge -> same restart action as INICIO (pulse, onda=1, pontuacao=0, go to JOGANDO).
- **Score:**
  - Every cycle in JOGANDO, kills = popcount(vivo_prev & ~inimigo_vivo). pontuacao += kills*PONTOS_INIMIGO, saturating at 16'hFFFF.
  - vivo_prev is updated every cycle in every state, so a respawn (0->1) never scores.
  - Kills in the same cycle as a perdeu or all-dead transition are still scored.
- **Lives:** vidas_prev is registered every cycle. Increases are ignored. vidas_prev is reloaded in the reiniciarJogo cycle so a restart refill is never seen as a loss.
- **Simultaneous events:** a pause edge coincident with any higher-priority event is discarded, not queued.
- **Reset mid-freeze or mid-pulse:** immediate return to INICIO; a partial reiniciarJogo pulse is cut.

Decomposition:
- Shared package jogo_pkg holds:
  - the state encodings (INICIO..FIM);
  - the default DIV_MV;
  - the N_INIMIGOS constant, shared with fileira.
- One sub-module, detector_borda: 2-FF sync plus rising-edge pulse, instantiated once per button.
- Popcount and divider stay inline.

Test Plan (bench uses DIV_MV=4, FREEZE_TICKS=3, N_INIMIGOS=5):
- Reset release, then btn_start high for 10 cycles -> exactly one reiniciarJogo pulse 3 cycles later, estado=1, onda=1, pausa=0 one cycle after. In JOGANDO, mv_tick pulses every 4 cycles.
- In JOGANDO, inimigo_vivo 11111->10110 in one cycle -> pontuacao=20. Then ->00000 -> pontuacao=50, estado=4, mv_tick=0. After 12 cycles: reiniciarJogo pulse, onda=2, estado=1. Vivo back to 11111 -> score stays 50.
- vidas 3->2 -> estado=3, pausa=1 for 3 raw ticks, then estado=1 with no reiniciarJogo.
- btn_pausa edge -> estado=2, mv_tick silent. Start edge -> no change. Second pause edge -> estado=1.
- perdeu=1, vidas drop and all enemies dead in the same cycle -> estado=5, kills scored. Start edge -> pontuacao=0, onda=1, estado=1.
- Assert reset during ONDA_LIMPA freeze -> all outputs at reset values asynchronously.
